step_dir_monitor: RTL and testbench

Receive-side decoder for the step/dir interface that the motor controller drives. It synchronises `step_in`/`dir_in` into the 10 MHz domain and maintains a signed position count. It measures the interval between step edges, flags when motion has stopped, and reports direction-setup violations. It sits on the feedback/loopback path beside the motor controller and is read by the host logic for position and velocity readback.

---
 rtl/motor_pkg.sv | 15 +
 rtl/sync_edge_detect.sv | 32 +++
 rtl/step_dir_monitor.sv | 139 +++++++++++++
 tb/tb_step_dir_monitor.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared step/dir constants and monitor state encoding
package motor_pkg;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    localparam int unsigned DEFAULT_STOP_TIMEOUT = 32'h0000_FFFF;

    typedef enum logic [1:0] {
        MON_IDLE  = 2'd0,
        MON_FIRST = 2'd1,
        MON_RUN   = 2'd2
    } mon_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - 2-FF synchroniser with registered rising-edge pulse
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic       meta;
    logic       sync_q;
    logic       prev;
    logic [1:0] primed;

    // prev is held high until sync_q carries a real sample, so a line that is
    // already high when reset releases never looks like a fresh edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta   <= 1'b0;
            sync_q <= 1'b0;
            prev   <= 1'b1;
            primed <= 2'b00;
            rise   <= 1'b0;
        end else begin
            meta   <= async_in;
            sync_q <= meta;
            primed <= {primed[0], 1'b1};
            prev   <= primed[1] ? sync_q : 1'b1;
            rise   <= sync_q & ~prev;
        end
    end

endmodule

// File: rtl/step_dir_monitor.sv
// rtl/step_dir_monitor.sv - step/dir receive decoder: position, step period, motion and dir-setup faults
module step_dir_monitor
    import motor_pkg::*;
#(
    parameter int          POS_W        = 16,
    parameter int          PERIOD_W     = 16,
    parameter int unsigned STOP_TIMEOUT = DEFAULT_STOP_TIMEOUT,
    parameter int          DIR_SETUP    = 2
) (
    input  logic                CLK_10MHZ,
    input  logic                rst,
    input  logic                step_in,
    input  logic                dir_in,
    input  logic                clear_pos,
    input  logic                fault_clr,
    output logic [POS_W-1:0]    position,
    output logic [PERIOD_W-1:0] period,
    output logic                period_valid,
    output logic                moving,
    output logic                step_event,
    output logic                dir_fault
);

    localparam int                  DS_W        = (DIR_SETUP < 1) ? 1 : $clog2(DIR_SETUP + 1);
    localparam logic [DS_W-1:0]     SETUP_CNT   = DS_W'(DIR_SETUP);
    localparam logic [PERIOD_W-1:0] TIMEOUT_CNT = PERIOD_W'(STOP_TIMEOUT);

    logic                step_rise;
    logic                dir_meta;
    logic                dir_sync;
    logic                dir_al;
    logic [DS_W-1:0]     dir_stable;
    logic                dir_short;
    logic [PERIOD_W-1:0] gap_cnt;
    logic [PERIOD_W-1:0] gap_next;
    logic                timeout;
    logic [POS_W-1:0]    pos_base;
    logic [POS_W-1:0]    pos_step;
    mon_state_t          state;
    mon_state_t          state_nxt;

    sync_edge_detect u_step_sync (
        .clk      (CLK_10MHZ),
        .rst      (rst),
        .async_in (step_in),
        .rise     (step_rise)
    );

    // dir_al is delayed one stage so it lines up with the registered step pulse.
    always_ff @(posedge CLK_10MHZ) begin
        if (rst) begin
            dir_meta   <= 1'b0;
            dir_sync   <= 1'b0;
            dir_al     <= 1'b0;
            dir_stable <= '0;
        end else begin
            dir_meta <= dir_in;
            dir_sync <= dir_meta;
            dir_al   <= dir_sync;
            if (dir_sync != dir_al)
                dir_stable <= '0;
            else if (dir_short)
                dir_stable <= dir_stable + 1'b1;
        end
    end

    always_comb begin
        dir_short = (dir_stable < SETUP_CNT);
        gap_next  = (&gap_cnt) ? gap_cnt : gap_cnt + 1'b1;
        timeout   = (gap_next == TIMEOUT_CNT);
        pos_base  = clear_pos ? '0 : position;
        pos_step  = pos_base;
        case (dir_al)
            DIR_FWD: pos_step = pos_base + 1'b1;
            DIR_REV: pos_step = pos_base - 1'b1;
            default: pos_step = pos_base;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MON_IDLE:  if (step_rise) state_nxt = MON_FIRST;
            MON_FIRST,
            MON_RUN: begin
                if (step_rise)
                    state_nxt = MON_RUN;
                else if (timeout)
                    state_nxt = MON_IDLE;
            end
            default:   state_nxt = MON_IDLE;
        endcase
    end

    always_ff @(posedge CLK_10MHZ) begin
        if (rst)
            state <= MON_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge CLK_10MHZ) begin
        if (rst) begin
            gap_cnt      <= '0;
            position     <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            moving       <= 1'b0;
            step_event   <= 1'b0;
            dir_fault    <= 1'b0;
        end else begin
            gap_cnt    <= step_rise ? PERIOD_W'(1) : gap_next;
            step_event <= step_rise;

            if (step_rise)
                position <= pos_step;
            else if (clear_pos)
                position <= '0;

            if (step_rise && dir_short)
                dir_fault <= 1'b1;
            else if (fault_clr)
                dir_fault <= 1'b0;

            if (step_rise) begin
                moving <= 1'b1;
                if (state != MON_IDLE) begin
                    period       <= gap_cnt;
                    period_valid <= 1'b1;
                end
            end else if (state != MON_IDLE && timeout) begin
                moving       <= 1'b0;
                period_valid <= 1'b0;
                period       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_step_dir_monitor.sv
// tb/tb_step_dir_monitor.sv - scoreboard bench for step_dir_monitor
module tb_step_dir_monitor;

    logic clk = 1'b0;
    always #50 clk = ~clk;

    logic        rst, step_in, dir_in, clear_pos, fault_clr;
    logic [15:0] position, period;
    logic        period_valid, moving, step_event, dir_fault;

    logic        step_to, dir_to;
    logic [15:0] position_to, period_to;
    logic        period_valid_to, moving_to, step_event_to, dir_fault_to;

    step_dir_monitor dut (
        .CLK_10MHZ    (clk),
        .rst          (rst),
        .step_in      (step_in),
        .dir_in       (dir_in),
        .clear_pos    (clear_pos),
        .fault_clr    (fault_clr),
        .position     (position),
        .period       (period),
        .period_valid (period_valid),
        .moving       (moving),
        .step_event   (step_event),
        .dir_fault    (dir_fault)
    );

    step_dir_monitor #(.STOP_TIMEOUT(100)) dut_to (
        .CLK_10MHZ    (clk),
        .rst          (rst),
        .step_in      (step_to),
        .dir_in       (dir_to),
        .clear_pos    (1'b0),
        .fault_clr    (1'b0),
        .position     (position_to),
        .period       (period_to),
        .period_valid (period_valid_to),
        .moving       (moving_to),
        .step_event   (step_event_to),
        .dir_fault    (dir_fault_to)
    );

    typedef struct packed {
        logic [15:0] pos;
        logic [15:0] per;
        logic        pv;
        logic        flt;
    } exp_t;

    exp_t exp_q[$];
    exp_t sb_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_position"}, position, 0);
        check({tag, "_period"}, period, 0);
        check({tag, "_period_valid"}, period_valid, 0);
        check({tag, "_moving"}, moving, 0);
        check({tag, "_step_event"}, step_event, 0);
        check({tag, "_dir_fault"}, dir_fault, 0);
    endtask

    task automatic expect_step(input logic [15:0] pos, input logic [15:0] per, input logic pv, input logic flt);
        exp_q.push_back({pos, per, pv, flt});
    endtask

    task automatic step(input int hi, input int lo, input logic [15:0] pos,
                        input logic [15:0] per, input logic pv, input logic flt);
        expect_step(pos, per, pv, flt);
        step_in = 1'b1;
        repeat (hi) @(negedge clk);
        step_in = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (step_event === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_step_event", {31'b0, step_event}, 0);
            end else begin
                sb_e = exp_q.pop_front();
                check("sb_position", position, sb_e.pos);
                check("sb_period", period, sb_e.per);
                check("sb_period_valid", period_valid, sb_e.pv);
                check("sb_moving", moving, 1);
                check("sb_dir_fault", dir_fault, sb_e.flt);
            end
        end
    end

    initial begin
        int cnt;
        int k;
        rst = 1'b1; step_in = 1'b0; dir_in = 1'b1; clear_pos = 1'b0; fault_clr = 1'b0;
        step_to = 1'b0; dir_to = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("rst0");
        rst = 1'b0;
        repeat (10) @(negedge clk);

        for (int i = 1; i <= 5; i++)
            step(1025, 1024, 16'(i), (i == 1) ? 16'd0 : 16'd2049, i != 1, 1'b0);
        check("fwd_position", position, 5);
        check("fwd_period_valid", period_valid, 1);

        dir_in = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset("rst1");
        repeat (10) @(negedge clk);
        step(4, 4, 16'hFFFF, 16'd0, 1'b0, 1'b0);
        step(4, 4, 16'hFFFE, 16'd8, 1'b1, 1'b0);
        step(4, 4, 16'hFFFD, 16'd8, 1'b1, 1'b0);
        check("rev_position", position, 16'hFFFD);
        dir_in = 1'b1;
        repeat (10) @(negedge clk);
        step(4, 4, 16'hFFFE, 16'd18, 1'b1, 1'b0);
        step(4, 4, 16'hFFFF, 16'd8, 1'b1, 1'b0);
        step(4, 4, 16'h0000, 16'd8, 1'b1, 1'b0);
        check("wrap_position", position, 0);
        check("wrap_dir_fault", dir_fault, 0);

        repeat (20) @(negedge clk);
        dir_in = 1'b0;
        @(negedge clk);
        step(4, 4, 16'hFFFF, 16'd29, 1'b1, 1'b1);
        check("viol_dir_fault", dir_fault, 1);
        repeat (5) @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        check("fault_clr_alone", dir_fault, 0);

        repeat (10) @(negedge clk);
        dir_in = 1'b1;
        @(negedge clk);
        expect_step(16'h0000, 16'd25, 1'b1, 1'b1);
        step_in = 1'b1;
        repeat (3) @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        step_in = 1'b0;
        repeat (4) @(negedge clk);
        check("fault_set_wins", dir_fault, 1);

        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        for (int i = 1; i <= 7; i++)
            step(4, 4, 16'(i), (i == 1) ? 16'd9 : 16'd8, 1'b1, 1'b0);
        check("pre_clear_position", position, 7);

        expect_step(16'h0001, 16'd8, 1'b1, 1'b0);
        step_in = 1'b1;
        repeat (3) @(negedge clk);
        clear_pos = 1'b1;
        @(negedge clk);
        clear_pos = 1'b0;
        step_in = 1'b0;
        repeat (4) @(negedge clk);
        check("clear_collide_position", position, 1);
        clear_pos = 1'b1;
        @(negedge clk);
        clear_pos = 1'b0;
        check("clear_alone_position", position, 0);

        expect_step(16'h0001, 16'd9, 1'b1, 1'b0);
        step_in = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset("rst_mid");
        repeat (20) @(negedge clk);
        check("held_high_position", position, 0);
        check("held_high_moving", moving, 0);
        step_in = 1'b0;
        repeat (4) @(negedge clk);
        step(4, 4, 16'h0001, 16'd0, 1'b0, 1'b0);

        step_to = 1'b1;
        repeat (4) @(negedge clk);
        step_to = 1'b0;
        repeat (4) @(negedge clk);
        step_to = 1'b1;
        cnt = 0;
        while (step_event_to !== 1'b1 && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check("to_second_event", step_event_to, 1);
        check("to_period", period_to, 8);
        check("to_period_valid", period_valid_to, 1);
        check("to_position", position_to, 2);
        k = 0;
        while (moving_to === 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
            if (k == 2) step_to = 1'b0;
        end
        check("to_fall_cycles", k, 99);
        check("to_idle_period_valid", period_valid_to, 0);
        check("to_idle_period", period_to, 0);
        check("to_idle_position", position_to, 2);
        step_to = 1'b1;
        cnt = 0;
        while (step_event_to !== 1'b1 && cnt < 10) begin
            @(negedge clk);
            cnt++;
        end
        check("to_reenter_event", step_event_to, 1);
        check("to_reenter_moving", moving_to, 1);
        check("to_reenter_period_valid", period_valid_to, 0);
        check("to_reenter_position", position_to, 3);
        check("to_dir_fault", dir_fault_to, 0);
        step_to = 1'b0;
        repeat (5) @(negedge clk);

        check("sb_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
